// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency min/max/add/sub ALU among NREQ
// requesters; one operation in flight, result returned tagged with requester id.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_in0,
    input  logic [WIDTH*NREQ-1:0]   req_in1,
    output logic [1:0]              alu_op,
    output logic [WIDTH-1:0]        alu_in0,
    output logic [WIDTH-1:0]        alu_in1,
    input  logic [WIDTH-1:0]        alu_out,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    input  logic                    rsp_ready,
    output logic                    busy
);
    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int SW = (NREQ < 2) ? 1 : $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  alu_in0_q, alu_in0_d;
    logic [WIDTH-1:0]  alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]   grant_oh;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  in0_sel, in1_sel;

    // Search starts one past the last grant so a steady requester set rotates.
    always_comb begin : rr_pick
        int j;
        logic [SW-1:0] sel;
        j         = 0;
        sel       = '0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        op_sel    = '0;
        in0_sel   = '0;
        in1_sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last_grant_q) + k;
            if (j >= NREQ) j = j - NREQ;
            sel = SW'(j);
            if (!grant_any && req_valid[sel]) begin
                grant_any     = 1'b1;
                grant_oh[sel] = 1'b1;
                grant_idx     = IDW'(j);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                op_sel  = req_op[2*i +: 2];
                in0_sel = req_in0[WIDTH*i +: WIDTH];
                in1_sel = req_in1[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_in0_d    = alu_in0_q;
        alu_in1_d    = alu_in1_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready    = grant_oh;
                    alu_op_d     = op_sel;
                    alu_in0_d    = in0_sel;
                    alu_in1_d    = in1_sel;
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CW'(ALU_LAT)) begin
                    rsp_data_d  = alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // No handshake may appear to complete while the edge will discard it.
        if (reset) req_ready = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_id_q     <= '0;
            cnt_q        <= '0;
            alu_op_q     <= '0;
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_in0_q    <= alu_in0_d;
            alu_in1_q    <= alu_in1_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_in0   = alu_in0_q;
    assign alu_in1   = alu_in1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 built with ALU_LAT=1, instance 1 with
// ALU_LAT=3, each paired with a delayed reference ALU; responses go through a scoreboard.
module tb_alu_share_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic         clock;
    logic         rst       [2];
    logic [3:0]   req_valid [2];
    logic [3:0]   req_ready [2];
    logic [7:0]   req_op    [2];
    logic [127:0] req_in0   [2];
    logic [127:0] req_in1   [2];
    logic [1:0]   alu_op    [2];
    logic [31:0]  alu_in0   [2];
    logic [31:0]  alu_in1   [2];
    logic [31:0]  alu_out   [2];
    logic         rsp_valid [2];
    logic [1:0]   rsp_id    [2];
    logic [31:0]  rsp_data  [2];
    logic         rsp_ready [2];
    logic         busy      [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_n [2];
    int   rsp_n [2];
    int   rsp_cyc [2];
    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return (a < b) ? a : b;
            2'd1:    return (a > b) ? a : b;
            2'd2:    return a + b;
            default: return a - b;
        endcase
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_dut
        localparam int LAT = (u == 0) ? 1 : 3;
        logic [31:0] pipe [LAT];
        always @(posedge clock) begin
            pipe[0] <= alu_f(alu_op[u], alu_in0[u], alu_in1[u]);
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign alu_out[u] = pipe[LAT-1];

        alu_share_arbiter #(.NREQ(4), .WIDTH(32), .IDW(2), .ALU_LAT(LAT)) dut (
            .clock(clock), .reset(rst[u]),
            .req_valid(req_valid[u]), .req_ready(req_ready[u]), .req_op(req_op[u]),
            .req_in0(req_in0[u]), .req_in1(req_in1[u]),
            .alu_op(alu_op[u]), .alu_in0(alu_in0[u]), .alu_in1(alu_in1[u]), .alu_out(alu_out[u]),
            .rsp_valid(rsp_valid[u]), .rsp_id(rsp_id[u]), .rsp_data(rsp_data[u]),
            .rsp_ready(rsp_ready[u]), .busy(busy[u])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int u, input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[u][2*i +: 2]   = op;
        req_in0[u][32*i +: 32] = a;
        req_in1[u][32*i +: 32] = b;
    endtask

    task automatic push(input int u, input logic [1:0] id, input logic [31:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Returns one cycle after the accept edge, with the accept cycle and granted index.
    task automatic wait_acc(input int u, output int c, output int g);
        c = -1;
        g = -1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (|(req_valid[u] & req_ready[u])) begin
                c = cyc;
                for (int k = 0; k < 4; k++) if (req_ready[u][k]) g = k;
                tick();
                return;
            end
            tick();
        end
        chk("accept_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int u);
        for (int n = 0; n < 40; n++) begin
            if (!busy[u]) return;
            tick();
        end
        chk("idle_timeout", 1, 0);
    endtask

    // Response monitor: every completed handshake pops the scoreboard.
    initial begin
        exp_t e;
        acc_n = '{0, 0};
        rsp_n = '{0, 0};
        rsp_cyc = '{0, 0};
        forever begin
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                if (!rst[u]) begin
                    if (|(req_valid[u] & req_ready[u])) acc_n[u]++;
                    if (rsp_valid[u] && rsp_ready[u]) begin
                        rsp_n[u]++;
                        rsp_cyc[u] = cyc;
                        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                            chk("unexpected_rsp", 1, 0);
                        end else begin
                            e = (u == 0) ? q0.pop_front() : q1.pop_front();
                            chk("rsp_id", 64'(rsp_id[u]), 64'(e.id));
                            chk("rsp_data", 64'(rsp_data[u]), 64'(e.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int a, c, g, prev, hc, n0;
        logic [1:0]  t3_op [4];
        logic [31:0] t3_a [4];
        logic [31:0] t3_b [4];
        logic [31:0] t3_r [4];
        t3_op = '{2'd1, 2'd2, 2'd3, 2'd0};
        t3_a  = '{32'd2, 32'd3, 32'd9, 32'd7};
        t3_b  = '{32'd3, 32'd5, 32'd12, 32'd4};
        t3_r  = '{32'd3, 32'd8, 32'hFFFF_FFFD, 32'd4};
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_valid[u] = '0; req_op[u] = '0;
            req_in0[u] = '0; req_in1[u] = '0; rsp_ready[u] = 1'b0;
        end
        req_valid[0] = 4'hF;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            chk("rst_req_ready", 64'(req_ready[u]), 0);
            chk("rst_busy", 64'(busy[u]), 0);
            chk("rst_rsp_valid", 64'(rsp_valid[u]), 0);
            chk("rst_alu_in0", 64'(alu_in0[u]), 0);
            chk("rst_alu_op", 64'(alu_op[u]), 0);
        end
        req_valid[0] = '0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // Reset while EXEC abandons the op; priority restarts at requester 0.
        rsp_ready[0] = 1'b1;
        set_req(0, 1, 2'd2, 32'd5, 32'd6);
        req_valid[0] = 4'b0010;
        wait_acc(0, a, g);
        req_valid[0] = '0;
        chk("t1_busy_exec", 64'(busy[0]), 1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("t1_busy", 64'(busy[0]), 0);
        chk("t1_rsp_valid", 64'(rsp_valid[0]), 0);
        chk("t1_rsp_data", 64'(rsp_data[0]), 0);
        chk("t1_rsp_id", 64'(rsp_id[0]), 0);
        chk("t1_alu_in0", 64'(alu_in0[0]), 0);
        repeat (6) tick();
        chk("t1_no_rsp", 64'(rsp_n[0]), 0);
        set_req(0, 0, 2'd2, 32'd1, 32'd2);
        set_req(0, 3, 2'd2, 32'd30, 32'd4);
        push(0, 2'd0, 32'd3);
        push(0, 2'd3, 32'd34);
        req_valid[0] = 4'b1001;
        #1;
        chk("t1_ready_first", 64'(req_ready[0]), 64'b0001);
        wait_acc(0, c, g);
        chk("t1_grant0", 64'(g), 0);
        req_valid[0] = 4'b1000;
        wait_acc(0, c, g);
        chk("t1_grant3", 64'(g), 3);
        req_valid[0] = '0;
        wait_idle(0);

        // Single requester timing with ALU_LAT=1.
        set_req(0, 1, 2'd0, 32'd1, 32'd0);
        push(0, 2'd1, 32'd0);
        req_valid[0] = 4'b0010;
        wait_acc(0, a, g);
        req_valid[0] = '0;
        chk("t2_grant", 64'(g), 1);
        chk("t2_busy_a1", 64'(busy[0]), 1);
        tick();
        chk("t2_rsp_valid_a2", 64'(rsp_valid[0]), 0);
        tick();
        chk("t2_rsp_valid_a3", 64'(rsp_valid[0]), 1);
        chk("t2_rsp_id_a3", 64'(rsp_id[0]), 1);
        chk("t2_rsp_data_a3", 64'(rsp_data[0]), 0);
        tick();
        chk("t2_busy_a4", 64'(busy[0]), 0);

        // All four ops back-to-back from requester 2.
        for (int k = 0; k < 4; k++) push(0, 2'd2, t3_r[k]);
        set_req(0, 2, t3_op[0], t3_a[0], t3_b[0]);
        req_valid[0] = 4'b0100;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_acc(0, c, g);
            chk("t3_grant", 64'(g), 2);
            if (k > 0) chk("t3_spacing", 64'(c - prev), 4);
            prev = c;
            if (k < 3) set_req(0, 2, t3_op[k+1], t3_a[k+1], t3_b[k+1]);
            else req_valid[0] = '0;
        end
        wait_idle(0);

        // Strict rotation from a fresh reset.
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 4; i++) set_req(0, i, 2'd2, 32'(i), 32'(10 * i));
        for (int k = 0; k < 5; k++) push(0, 2'(k % 4), 32'(11 * (k % 4)));
        req_valid[0] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_acc(0, c, g);
            chk("t4_rr_grant", 64'(g), 64'(k % 4));
        end
        req_valid[0] = '0;
        wait_idle(0);

        // Back-pressure holds the response; pending request waits for IDLE.
        rsp_ready[0] = 1'b0;
        set_req(0, 0, 2'd2, 32'd40, 32'd2);
        push(0, 2'd0, 32'd42);
        req_valid[0] = 4'b0001;
        wait_acc(0, a, g);
        chk("t5_grant", 64'(g), 0);
        set_req(0, 1, 2'd3, 32'd1, 32'd2);
        push(0, 2'd1, 32'hFFFF_FFFF);
        req_valid[0] = 4'b0010;
        for (int n = 0; n < 20 && !rsp_valid[0]; n++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", 64'(rsp_valid[0]), 1);
            chk("t5_hold_id", 64'(rsp_id[0]), 0);
            chk("t5_hold_data", 64'(rsp_data[0]), 42);
            chk("t5_ready_low", 64'(req_ready[0]), 0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        hc = cyc;
        wait_acc(0, c, g);
        req_valid[0] = '0;
        chk("t5_rsp_cycle", 64'(rsp_cyc[0]), 64'(hc));
        chk("t5_next_grant_cycle", 64'(c), 64'(hc + 1));
        chk("t5_next_grant", 64'(g), 1);
        wait_idle(0);
        tick();

        // ALU_LAT=3 instance; a request withdrawn while busy is never served.
        rsp_ready[1] = 1'b1;
        set_req(1, 0, 2'd2, 32'd100, 32'd23);
        push(1, 2'd0, 32'd123);
        req_valid[1] = 4'b0001;
        wait_acc(1, a, g);
        set_req(1, 2, 2'd2, 32'd7, 32'd7);
        req_valid[1] = 4'b0100;
        tick();
        req_valid[1] = '0;
        tick();
        tick();
        chk("t6_rsp_valid_a4", 64'(rsp_valid[1]), 0);
        tick();
        chk("t6_rsp_valid_a5", 64'(rsp_valid[1]), 1);
        chk("t6_rsp_data_a5", 64'(rsp_data[1]), 123);
        n0 = acc_n[1];
        repeat (8) tick();
        chk("t6_no_withdrawn_grant", 64'(acc_n[1]), 64'(n0));
        chk("t6_idle", 64'(busy[1]), 0);

        chk("sb0_drained", 64'(q0.size()), 0);
        chk("sb1_drained", 64'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
